// File: rtl/sdram_port_arbiter.sv
// Two-master Avalon-MM arbiter sharing one SDRAM controller port, with a read-tag FIFO
// that routes pipelined read returns. Define SDRAM_ARB_FIXED_PRIO_EN for m0 fixed priority.
module sdram_port_arbiter #(
  parameter int unsigned ADDR_W   = 25,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned BE_W     = 4,
  parameter int unsigned MAX_PEND = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  output logic [BE_W-1:0]   s_byteenable,
  input  logic              s_waitrequest,
  input  logic [DATA_W-1:0] s_readdata,
  input  logic              s_readdatavalid,
  output logic              err_orphan
);

  localparam int unsigned PTR_W = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_PEND + 1);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t              state, state_nxt;
  logic                last;
  logic [MAX_PEND-1:0] tag_mem;
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;

  logic req0, req1, rd0, rd1;
  logic tag_full, tag_empty;
  logic block, accept, push, pop, gnt_id, ret_tag;

  // write wins when a master illegally raises both strobes
  assign req0      = m0_read | m0_write;
  assign req1      = m1_read | m1_write;
  assign rd0       = m0_read & ~m0_write;
  assign rd1       = m1_read & ~m1_write;
  assign tag_full  = (count == CNT_W'(MAX_PEND));
  assign tag_empty = (count == '0);

  // Grant FSM and request pass-through
  always_comb begin
    state_nxt      = state;
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    block          = 1'b0;
    accept         = 1'b0;
    push           = 1'b0;
    gnt_id         = 1'b0;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
          state_nxt = GNT0;
`else
          state_nxt = last ? GNT0 : GNT1;
`endif
        end else if (req0) begin
          state_nxt = GNT0;
        end else if (req1) begin
          state_nxt = GNT1;
        end
      end
      GNT0: begin
        block          = rd0 & tag_full;
        s_address      = m0_address;
        s_write        = m0_write;
        s_read         = rd0 & ~block;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        m0_waitrequest = s_waitrequest | block;
        accept         = (m0_write | s_read) & ~s_waitrequest;
        push           = accept & rd0;
        gnt_id         = 1'b0;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        if (!req0) state_nxt = req1 ? GNT1 : IDLE;
`else
        if ((accept && req1) || (!req0 && req1)) state_nxt = GNT1;
        else if (!req0)                          state_nxt = IDLE;
`endif
      end
      GNT1: begin
        block          = rd1 & tag_full;
        s_address      = m1_address;
        s_write        = m1_write;
        s_read         = rd1 & ~block;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m1_waitrequest = s_waitrequest | block;
        accept         = (m1_write | s_read) & ~s_waitrequest;
        push           = accept & rd1;
        gnt_id         = 1'b1;
        if ((accept && req0) || (!req1 && req0)) state_nxt = GNT0;
        else if (!req1)                          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read return routing, zero latency from the controller
  assign pop              = s_readdatavalid & ~tag_empty;
  assign ret_tag          = tag_mem[rd_ptr];
  assign m0_readdatavalid = pop & ~ret_tag;
  assign m1_readdatavalid = pop & ret_tag;
  assign m0_readdata      = m0_readdatavalid ? s_readdata : '0;
  assign m1_readdata      = m1_readdatavalid ? s_readdata : '0;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state      <= IDLE;
      last       <= 1'b1;
      tag_mem    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      err_orphan <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) last <= gnt_id;
      if (push) begin
        tag_mem[wr_ptr] <= gnt_id;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // a return with nothing outstanding has no owner; flag it until reset
      if (s_readdatavalid && tag_empty) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed self-checking bench for sdram_port_arbiter (tag FIFO depth 4).
module tb_sdram_port_arbiter;
  localparam int unsigned ADDR_W = 25;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned PEND   = 4;

  logic              clk_clk, reset_reset_n;
  logic [ADDR_W-1:0] m0_address, m1_address, s_address;
  logic              m0_read, m0_write, m1_read, m1_write;
  logic [DATA_W-1:0] m0_writedata, m1_writedata, s_writedata;
  logic [BE_W-1:0]   m0_byteenable, m1_byteenable, s_byteenable;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata, s_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic              s_read, s_write, s_waitrequest, s_readdatavalid, err_orphan;

  int checks = 0;
  int errors = 0;

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .MAX_PEND(PEND)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .err_orphan(err_orphan)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // inputs change 1 time unit after the rising edge, checks 2 units later
  task automatic cyc();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
    m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0;
    s_waitrequest = 0; s_readdata = '0; s_readdatavalid = 0;
    reset_reset_n = 1;
    #1 reset_reset_n = 0;
    settle();
    chk("rst_s_read", 64'(s_read), 0);
    chk("rst_s_write", 64'(s_write), 0);
    chk("rst_m0_wait", 64'(m0_waitrequest), 1);
    chk("rst_m1_wait", 64'(m1_waitrequest), 1);
    chk("rst_m0_rdv", 64'(m0_readdatavalid), 0);
    chk("rst_m1_rdv", 64'(m1_readdatavalid), 0);
    chk("rst_m0_rdata", 64'(m0_readdata), 0);
    chk("rst_m1_rdata", 64'(m1_readdata), 0);
    chk("rst_orphan", 64'(err_orphan), 0);
    cyc(); cyc();
    reset_reset_n = 1;

    // both masters read continuously: grants alternate starting with m0
    m0_read = 1; m0_address = 25'h100;
    m1_read = 1; m1_address = 25'h200;
    settle();
    chk("alt_idle_s_read", 64'(s_read), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(); settle();
      chk("alt_s_read", 64'(s_read), 1);
      chk("alt_s_addr", 64'(s_address), (i % 2 == 0) ? 64'h100 : 64'h200);
      chk("alt_m0_wait", 64'(m0_waitrequest), (i % 2 == 0) ? 64'd0 : 64'd1);
      chk("alt_m1_wait", 64'(m1_waitrequest), (i % 2 == 0) ? 64'd1 : 64'd0);
    end
    cyc(); m0_read = 0; settle();
    chk("alt4_s_addr", 64'(s_address), 64'h200);
    chk("alt4_m1_wait", 64'(m1_waitrequest), 0);
    cyc(); m1_read = 0; s_readdatavalid = 1; s_readdata = 32'hA; settle();
    chk("alt_done_s_read", 64'(s_read), 0);
    chk("ret0_m0_rdv", 64'(m0_readdatavalid), 1);
    chk("ret0_m0_data", 64'(m0_readdata), 64'hA);
    chk("ret0_m1_rdv", 64'(m1_readdatavalid), 0);
    for (int i = 1; i < 4; i++) begin
      cyc(); s_readdata = 32'(10 + i); settle();
      chk("ret_m0_rdv", 64'(m0_readdatavalid), (i % 2 == 0) ? 64'd1 : 64'd0);
      chk("ret_m1_rdv", 64'(m1_readdatavalid), (i % 2 == 1) ? 64'd1 : 64'd0);
      if (i % 2 == 1) chk("ret_m1_data", 64'(m1_readdata), 64'(10 + i));
      else            chk("ret_m0_data", 64'(m0_readdata), 64'(10 + i));
    end

    // return with no tag pending is dropped and flagged
    cyc(); s_readdata = 32'hEE; settle();
    chk("orph_m0_rdv", 64'(m0_readdatavalid), 0);
    chk("orph_m1_rdv", 64'(m1_readdatavalid), 0);
    chk("orph_not_yet", 64'(err_orphan), 0);
    cyc(); s_readdatavalid = 0; settle();
    chk("orph_set", 64'(err_orphan), 1);
    cyc(); cyc(); settle();
    chk("orph_sticky", 64'(err_orphan), 1);

    // m0 issues PEND+1 reads with no returns: last one held until a return frees a tag
    cyc(); m0_read = 1; m0_address = 25'h300; settle();
    for (int i = 0; i < 4; i++) begin
      cyc(); settle();
      chk("fill_s_read", 64'(s_read), 1);
      chk("fill_m0_wait", 64'(m0_waitrequest), 0);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(); settle();
      chk("full_s_read", 64'(s_read), 0);
      chk("full_m0_wait", 64'(m0_waitrequest), 1);
    end
    cyc(); s_readdatavalid = 1; s_readdata = 32'h55; settle();
    chk("full_ret_rdv", 64'(m0_readdatavalid), 1);
    chk("full_ret_data", 64'(m0_readdata), 64'h55);
    chk("full_ret_s_read", 64'(s_read), 0);
    cyc(); s_readdatavalid = 0; settle();
    chk("full_free_s_read", 64'(s_read), 1);
    chk("full_free_m0_wait", 64'(m0_waitrequest), 0);
    cyc(); m0_read = 0; settle();
    for (int i = 0; i < 4; i++) begin
      cyc(); s_readdatavalid = 1; s_readdata = 32'(32'h60 + i); settle();
      chk("drain_m0_rdv", 64'(m0_readdatavalid), 1);
      chk("drain_m0_data", 64'(m0_readdata), 64'(32'h60 + i));
      chk("drain_m1_rdv", 64'(m1_readdatavalid), 0);
    end

    // m1 write stalled by the controller; m0 waits until m1 is accepted
    cyc();
    s_readdatavalid = 0; s_waitrequest = 1;
    m1_write = 1; m1_address = 25'h20; m1_writedata = 32'h12345678; m1_byteenable = 4'h3;
    m0_write = 1; m0_address = 25'h10; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
    settle();
    chk("stall_idle_m1_wait", 64'(m1_waitrequest), 1);
    for (int i = 0; i < 5; i++) begin
      cyc(); settle();
      chk("stall_s_write", 64'(s_write), 1);
      chk("stall_s_addr", 64'(s_address), 64'h20);
      chk("stall_s_wdata", 64'(s_writedata), 64'h12345678);
      chk("stall_s_be", 64'(s_byteenable), 64'h3);
      chk("stall_m1_wait", 64'(m1_waitrequest), 1);
      chk("stall_m0_wait", 64'(m0_waitrequest), 1);
    end
    cyc(); s_waitrequest = 0; settle();
    chk("stall_rel_m1_wait", 64'(m1_waitrequest), 0);
    chk("stall_rel_m0_wait", 64'(m0_waitrequest), 1);
    cyc(); m1_write = 0; settle();
    chk("after_m0_addr", 64'(s_address), 64'h10);
    chk("after_m0_wdata", 64'(s_writedata), 64'hDEADBEEF);
    chk("after_m0_wait", 64'(m0_waitrequest), 0);
    chk("after_m1_wait", 64'(m1_waitrequest), 1);
    cyc(); m0_write = 0; settle();
    chk("after_s_write", 64'(s_write), 0);
    cyc(); settle();
    chk("after_idle_m0_wait", 64'(m0_waitrequest), 1);

    // single m0 write from idle: one-cycle grant latency
    m0_write = 1; m0_address = 25'h10; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
    #1;
    chk("wr_idle_s_write", 64'(s_write), 0);
    cyc(); settle();
    chk("wr_s_write", 64'(s_write), 1);
    chk("wr_s_addr", 64'(s_address), 64'h10);
    chk("wr_s_wdata", 64'(s_writedata), 64'hDEADBEEF);
    chk("wr_s_be", 64'(s_byteenable), 64'hF);
    chk("wr_m0_wait", 64'(m0_waitrequest), 0);
    cyc(); m0_write = 0; settle();
    cyc(); settle();
    chk("wr_back_idle", 64'(m0_waitrequest), 1);
    chk("wr_back_s_write", 64'(s_write), 0);

    // reset with reads outstanding drops all tags
    cyc(); m1_read = 1; m1_address = 25'h400; settle();
    for (int i = 0; i < 3; i++) begin
      cyc(); settle();
      chk("pend_s_read", 64'(s_read), 1);
      chk("pend_m1_wait", 64'(m1_waitrequest), 0);
    end
    cyc(); settle();
    reset_reset_n = 0;
    #1;
    chk("mid_rst_s_read", 64'(s_read), 0);
    chk("mid_rst_m1_wait", 64'(m1_waitrequest), 1);
    chk("mid_rst_m0_wait", 64'(m0_waitrequest), 1);
    chk("mid_rst_orphan", 64'(err_orphan), 0);
    m1_read = 0;
    cyc(); cyc();
    reset_reset_n = 1;
    s_readdatavalid = 1; s_readdata = 32'h77;
    settle();
    chk("post_rst_m0_rdv", 64'(m0_readdatavalid), 0);
    chk("post_rst_m1_rdv", 64'(m1_readdatavalid), 0);
    cyc(); s_readdatavalid = 0; settle();
    chk("post_rst_orphan", 64'(err_orphan), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
